// File: rtl/ps2_key_event_decoder.sv
// PS/2 key event decoder: turns the scan-code byte stream into make/break
// events, tracks modifier and CapsLock state, maps keys to ASCII and queues
// events in a show-ahead ready/valid FIFO.
// Ports:
//   clk, rst (async, active-low)
//   rx_data/rx_valid        : byte stream from the PS/2 receiver
//   evt_ready               : consumer pops the head event
//   clr_overflow            : clears the sticky overflow flag
//   evt_valid/code/ext/break/ascii : head event of the FIFO (0 when empty)
//   shift/ctrl/alt_flag, caps_lock : modifier state
//   press_cnt               : accepted make events, wrapping
//   fifo_count, overflow    : FIFO occupancy and sticky drop flag
module ps2_key_event_decoder #(
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned TYPEMATIC_FILTER = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        evt_ready,
  input  logic                        clr_overflow,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic [7:0]                  evt_ascii,
  output logic                        shift_flag,
  output logic                        ctrl_flag,
  output logic                        alt_flag,
  output logic                        caps_lock,
  output logic [CNT_W-1:0]            press_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_gen, w_ext, w_brk;
  logic               w_is_resp, w_is_pfx;
  logic [8:0]         w_key;
  logic               w_repeat, w_accept, w_last_hit;
  logic               r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps;
  logic               w_lshift, w_rshift, w_lctrl, w_rctrl, w_lalt, w_ralt, w_caps;
  logic [8:0]         r_last_key;
  logic               r_last_vld;
  logic [CNT_W-1:0]   r_press_cnt;
  evt_t               r_mem [FIFO_DEPTH];
  evt_t               w_evt, w_head;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]   r_count;
  logic               r_ovf;
  logic               w_full, w_pop, w_push, w_ovf_set;

  // Scan code to ASCII; upper selects capital letters, shift selects digit symbols
  function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic upper,
                                         input logic shift);
    logic [7:0] l;
    logic [7:0] a;
    l = 8'h00;
    a = 8'h00;
    case (code)
      8'h1C: l = 8'h61;  8'h32: l = 8'h62;  8'h21: l = 8'h63;  8'h23: l = 8'h64;
      8'h24: l = 8'h65;  8'h2B: l = 8'h66;  8'h34: l = 8'h67;  8'h33: l = 8'h68;
      8'h43: l = 8'h69;  8'h3B: l = 8'h6A;  8'h42: l = 8'h6B;  8'h4B: l = 8'h6C;
      8'h3A: l = 8'h6D;  8'h31: l = 8'h6E;  8'h44: l = 8'h6F;  8'h4D: l = 8'h70;
      8'h15: l = 8'h71;  8'h2D: l = 8'h72;  8'h1B: l = 8'h73;  8'h2C: l = 8'h74;
      8'h3C: l = 8'h75;  8'h2A: l = 8'h76;  8'h1D: l = 8'h77;  8'h22: l = 8'h78;
      8'h35: l = 8'h79;  8'h1A: l = 8'h7A;
      8'h16: a = shift ? 8'h21 : 8'h31;
      8'h1E: a = shift ? 8'h40 : 8'h32;
      8'h26: a = shift ? 8'h23 : 8'h33;
      8'h25: a = shift ? 8'h24 : 8'h34;
      8'h2E: a = shift ? 8'h25 : 8'h35;
      8'h36: a = shift ? 8'h5E : 8'h36;
      8'h3D: a = shift ? 8'h26 : 8'h37;
      8'h3E: a = shift ? 8'h2A : 8'h38;
      8'h46: a = shift ? 8'h28 : 8'h39;
      8'h45: a = shift ? 8'h29 : 8'h30;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    if (l != 8'h00) a = upper ? (l - 8'h20) : l;
    return a;
  endfunction

  assign w_is_pfx  = (rx_data == 8'hE0) || (rx_data == 8'hF0);
  assign w_is_resp = (rx_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});

  // Prefix state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Prefix decoding and event generation
  always_comb begin
    w_state_nxt = r_state;
    w_gen       = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      w_state_nxt = S_EXT;
          else if (rx_data == 8'hF0) w_state_nxt = S_BRK;
          else if (!w_is_resp)       w_gen = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) w_state_nxt = S_EXT_BRK;
          else if (rx_data != 8'hE0) begin
            w_gen       = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          if (!w_is_pfx) begin
            w_gen       = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (!w_is_pfx) begin
            w_gen       = 1'b1;
            w_ext       = 1'b1;
            w_brk       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_key      = {w_ext, rx_data};
  assign w_last_hit = r_last_vld && (r_last_key == w_key);
  assign w_repeat   = (TYPEMATIC_FILTER != 0) && w_gen && !w_brk && w_last_hit;
  assign w_accept   = w_gen && !w_repeat;

  // Next modifier state; ASCII must see the state after this event's update
  always_comb begin
    w_lshift = r_lshift;
    w_rshift = r_rshift;
    w_lctrl  = r_lctrl;
    w_rctrl  = r_rctrl;
    w_lalt   = r_lalt;
    w_ralt   = r_ralt;
    w_caps   = r_caps;
    if (w_accept) begin
      case (rx_data)
        8'h12: w_lshift = !w_brk;
        8'h59: w_rshift = !w_brk;
        8'h14: if (w_ext) w_rctrl = !w_brk; else w_lctrl = !w_brk;
        8'h11: if (w_ext) w_ralt = !w_brk; else w_lalt = !w_brk;
        8'h58: if (!w_ext && !w_brk) w_caps = !r_caps;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_evt.code  = rx_data;
    w_evt.ext   = w_ext;
    w_evt.brk   = w_brk;
    w_evt.ascii = w_ext ? 8'h00
                        : f_ascii(rx_data, (w_lshift | w_rshift) ^ w_caps, w_lshift | w_rshift);
  end

  assign w_full    = (r_count == OCC_W'(FIFO_DEPTH));
  assign w_pop     = evt_valid && evt_ready;
  assign w_push    = w_accept && (!w_full || w_pop);
  assign w_ovf_set = w_accept && w_full && !w_pop;

  // Modifiers, typematic memory, press counter and FIFO control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps} <= '0;
      r_last_key  <= '0;
      r_last_vld  <= 1'b0;
      r_press_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      {r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt, r_caps} <=
        {w_lshift, w_rshift, w_lctrl, w_rctrl, w_lalt, w_ralt, w_caps};
      if (w_accept && !w_brk) begin
        r_last_key  <= w_key;
        r_last_vld  <= 1'b1;
        r_press_cnt <= r_press_cnt + CNT_W'(1);
      end else if (w_gen && w_brk && w_last_hit) begin
        r_last_vld <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: ;
      endcase
      if (w_ovf_set)         r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  // Event storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt;
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign evt_valid  = (r_count != '0);
  assign evt_code   = evt_valid ? w_head.code  : 8'h00;
  assign evt_ext    = evt_valid ? w_head.ext   : 1'b0;
  assign evt_break  = evt_valid ? w_head.brk   : 1'b0;
  assign evt_ascii  = evt_valid ? w_head.ascii : 8'h00;
  assign shift_flag = r_lshift | r_rshift;
  assign ctrl_flag  = r_lctrl | r_rctrl;
  assign alt_flag   = r_lalt | r_ralt;
  assign caps_lock  = r_caps;
  assign press_cnt  = r_press_cnt;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
